// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   FIFO of pending stores between the MEM-stage pipeline and datamemory.
//   Stores are accepted in one cycle and drained to datamemory whenever the
//   memory port is not claimed by a load. Loads have priority on the port.
//   A load whose word address matches any buffered store is stalled until
//   that store has drained, which keeps read-after-write ordering intact.
//   Data is never forwarded out of the buffer.
//
// Handshake: a store is transferred on a rising clk edge where
//   st_valid && st_ready. st_ready depends only on the occupancy count, never
//   on st_valid or on a pop in the same cycle. A load is served in any cycle
//   where ld_valid && !ld_stall; while ld_stall is high the pipeline holds
//   the load unchanged.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   st_valid/st_addr/st_data/st_funct3 -> st_ready   store request
//   ld_valid/ld_addr/ld_funct3   -> ld_stall          load request
//   dm_MemRead/dm_MemWrite/dm_a/dm_wd/dm_Funct3       datamemory port
//   empty, count                 occupancy status
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DM_ADDRESS    = 9,
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 4,
    // Simulation-only check that a store and a load are never requested in
    // the same cycle; a bench that deliberately overlaps them can clear it.
    parameter bit ASSERT_ONE_OP = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    input  logic [DM_ADDRESS-1:0]      st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [DM_ADDRESS-1:0]      ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       ld_stall,
    output logic                       dm_MemRead,
    output logic                       dm_MemWrite,
    output logic [DM_ADDRESS-1:0]      dm_a,
    output logic [DATA_W-1:0]          dm_wd,
    output logic [2:0]                 dm_Funct3,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; only the occupancy bookkeeping needs a reset.
    logic [DM_ADDRESS-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0]     r_data  [DEPTH];
    logic [2:0]            r_f3    [DEPTH];

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic [DEPTH-1:0]      w_entry_valid;
    logic                  w_hit;
    logic                  w_ld_go;
    logic                  w_pop;
    logic                  w_push;

    // An entry is live when its distance from the head (mod DEPTH) is below
    // the occupancy count.
    always_comb begin
        logic [PTR_W-1:0] v_off;
        w_entry_valid = '0;
        v_off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_off            = PTR_W'(i) - r_rd_ptr;
            w_entry_valid[i] = ({1'b0, v_off} < r_count);
        end
    end

    // Word-granular, conservative overlap check: byte lanes are ignored.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] &&
                (r_addr[i][DM_ADDRESS-1:2] == ld_addr[DM_ADDRESS-1:2])) begin
                w_hit = 1'b1;
            end
        end
        w_hit = w_hit & ld_valid;
    end

    // reset_n gating keeps the load request off the port while in reset.
    assign w_ld_go  = ld_valid & ~w_hit & reset_n;
    assign w_pop    = ~w_ld_go & (r_count != '0);
    assign st_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = st_valid & st_ready & reset_n;

    assign ld_stall = w_hit;
    assign empty    = (r_count == '0);
    assign count    = r_count;

    // Port arbitration: unstalled load first, then drain the head entry.
    always_comb begin
        dm_MemRead  = 1'b0;
        dm_MemWrite = 1'b0;
        dm_a        = '0;
        dm_wd       = '0;
        dm_Funct3   = '0;
        if (w_ld_go) begin
            dm_MemRead = 1'b1;
            dm_a       = ld_addr;
            dm_Funct3  = ld_funct3;
        end else if (w_pop) begin
            dm_MemWrite = 1'b1;
            dm_a        = r_addr[r_rd_ptr];
            dm_wd       = r_data[r_rd_ptr];
            dm_Funct3   = r_f3[r_rd_ptr];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The write pointer never points at a live entry while st_ready is high,
    // so a push cannot overwrite the head being drained this cycle.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= st_addr;
            r_data[r_wr_ptr] <= st_data;
            r_f3[r_wr_ptr]   <= st_funct3;
        end
    end

    generate
        if (ASSERT_ONE_OP) begin : g_one_op
            a_one_op : assert property (@(posedge clk) disable iff (!reset_n)
                                        !(st_valid && ld_valid));
        end
    endgenerate

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Self-checking bench for store_buffer. A queue-based reference model
//   tracks the buffered stores and derives every expected output from the
//   load-priority / drain-on-idle rules.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [2:0]    st_funct3;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_funct3;
    logic          ld_stall;
    logic          dm_MemRead;
    logic          dm_MemWrite;
    logic [AW-1:0] dm_a;
    logic [DW-1:0] dm_wd;
    logic [2:0]    dm_Funct3;
    logic          empty;
    logic [2:0]    count;

    int n_cmp = 0;
    int n_bad = 0;

    store_buffer #(.DM_ADDRESS(AW), .DATA_W(DW), .DEPTH(DEPTH), .ASSERT_ONE_OP(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_stall(ld_stall),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_a(dm_a), .dm_wd(dm_wd),
        .dm_Funct3(dm_Funct3), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    f;
    } ent_t;

    ent_t mq[$];

    logic          e_st_ready, e_ld_stall, e_rd, e_wr, e_empty;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wd;
    logic [2:0]    e_f3;
    logic [2:0]    e_count;

    function automatic void model_eval();
        logic hit;
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].a[AW-1:2] == ld_addr[AW-1:2]) hit = 1'b1;
        hit        = hit && ld_valid && reset_n;
        e_st_ready = (mq.size() < DEPTH);
        e_ld_stall = hit;
        e_rd = 1'b0; e_wr = 1'b0; e_a = '0; e_wd = '0; e_f3 = '0;
        if (reset_n && ld_valid && !hit) begin
            e_rd = 1'b1; e_a = ld_addr; e_f3 = ld_funct3;
        end else if (mq.size() > 0) begin
            e_wr = 1'b1; e_a = mq[0].a; e_wd = mq[0].d; e_f3 = mq[0].f;
        end
        e_count = 3'(mq.size());
        e_empty = (mq.size() == 0);
    endfunction

    // Advance one clock, applying the model's pop/push at the rising edge.
    task automatic step();
        logic do_pop, do_push;
        model_eval();
        do_pop  = e_wr && reset_n;
        do_push = st_valid && e_st_ready && reset_n;
        @(posedge clk);
        if (reset_n) begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{a: st_addr, d: st_data, f: st_funct3});
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 9'h0A4; ld_funct3 = 3'b010;
        @(negedge clk); #1;
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL rst_st_ready got %b want 1", st_ready); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", empty); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count); end
        n_cmp++; if (dm_MemWrite !== 1'b0) begin n_bad++; $display("FAIL rst_memwrite got %b want 0", dm_MemWrite); end
        n_cmp++; if (dm_MemRead !== 1'b0) begin n_bad++; $display("FAIL rst_memread got %b want 0", dm_MemRead); end
        n_cmp++; if (dm_a !== 9'h0) begin n_bad++; $display("FAIL rst_dm_a got %h want 0", dm_a); end
        n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL rst_ld_stall got %b want 0", ld_stall); end
        idle_inputs();
        reset_n = 1'b1;
        mq.delete();
        #1;
        n_cmp++; if (st_ready !== 1'b1 || empty !== 1'b1 || count !== 3'd0)
            begin n_bad++; $display("FAIL rel_state got rdy=%b empty=%b count=%0d want 1 1 0", st_ready, empty, count); end
        n_cmp++; if (dm_MemWrite !== 1'b0 || dm_MemRead !== 1'b0)
            begin n_bad++; $display("FAIL rel_port got rd=%b wr=%b want 0 0", dm_MemRead, dm_MemWrite); end
        step();
    endtask

    task automatic test_single_drain();
        st_valid = 1'b1; st_addr = 9'h010; st_data = 32'hDEADBEEF; st_funct3 = 3'b010;
        #1;
        n_cmp++; if (st_ready !== 1'b1) begin n_bad++; $display("FAIL sd_ready got %b want 1", st_ready); end
        n_cmp++; if (dm_MemWrite !== 1'b0) begin n_bad++; $display("FAIL sd_no_bypass got %b want 0", dm_MemWrite); end
        step();
        idle_inputs(); #1;
        n_cmp++; if (dm_MemWrite !== 1'b1) begin n_bad++; $display("FAIL sd_memwrite got %b want 1", dm_MemWrite); end
        n_cmp++; if (dm_a !== 9'h010) begin n_bad++; $display("FAIL sd_addr got %h want 010", dm_a); end
        n_cmp++; if (dm_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sd_data got %h want deadbeef", dm_wd); end
        n_cmp++; if (dm_Funct3 !== 3'b010) begin n_bad++; $display("FAIL sd_funct3 got %b want 010", dm_Funct3); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL sd_count got %0d want 1", count); end
        step(); #1;
        n_cmp++; if (empty !== 1'b1 || dm_MemWrite !== 1'b0)
            begin n_bad++; $display("FAIL sd_drained got empty=%b wr=%b want 1 0", empty, dm_MemWrite); end
    endtask

    task automatic test_fill_under_load();
        logic [DW-1:0] d [DEPTH];
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 9'h100; ld_funct3 = 3'b010;
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = $urandom;
            st_valid = 1'b1; st_addr = 9'(9'h040 + 4 * i); st_data = d[i]; st_funct3 = 3'b010;
            #1;
            n_cmp++; if (dm_MemRead !== 1'b1 || dm_MemWrite !== 1'b0 || dm_a !== 9'h100)
                begin n_bad++; $display("FAIL fill_port[%0d] got rd=%b wr=%b a=%h want 1 0 100", i, dm_MemRead, dm_MemWrite, dm_a); end
            n_cmp++; if (st_ready !== 1'b1 || count !== 3'(i))
                begin n_bad++; $display("FAIL fill_occ[%0d] got rdy=%b count=%0d want 1 %0d", i, st_ready, count, i); end
            step();
        end
        st_addr = 9'h0F0; st_data = 32'h5555AAAA; #1;
        n_cmp++; if (count !== 3'd4 || st_ready !== 1'b0 || dm_MemWrite !== 1'b0)
            begin n_bad++; $display("FAIL fill_full got count=%0d rdy=%b wr=%b want 4 0 0", count, st_ready, dm_MemWrite); end
        step();
        ld_valid = 1'b0; #1;
        n_cmp++; if (st_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_ready got %b want 0", st_ready); end
        for (int j = 0; j < DEPTH; j++) begin
            if (j == 1) st_valid = 1'b0;
            #1;
            n_cmp++; if (dm_MemWrite !== 1'b1 || dm_a !== 9'(9'h040 + 4 * j) || dm_wd !== d[j])
                begin n_bad++; $display("FAIL fill_drain[%0d] got wr=%b a=%h d=%h want 1 %h %h", j, dm_MemWrite, dm_a, dm_wd, 9'(9'h040 + 4 * j), d[j]); end
            step();
        end
        #1;
        n_cmp++; if (empty !== 1'b1 || dm_MemWrite !== 1'b0)
            begin n_bad++; $display("FAIL fill_empty got empty=%b wr=%b want 1 0", empty, dm_MemWrite); end
    endtask

    task automatic test_raw_stall();
        idle_inputs();
        st_valid = 1'b1; st_addr = 9'h021; st_data = 32'h000000AB; st_funct3 = 3'b000;
        step();
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 9'h020; ld_funct3 = 3'b010; #1;
        n_cmp++; if (ld_stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall got %b want 1", ld_stall); end
        n_cmp++; if (dm_MemWrite !== 1'b1 || dm_MemRead !== 1'b0 || dm_a !== 9'h021 || dm_wd !== 32'hAB || dm_Funct3 !== 3'b000)
            begin n_bad++; $display("FAIL raw_drain got wr=%b rd=%b a=%h d=%h f=%b want 1 0 021 ab 000", dm_MemWrite, dm_MemRead, dm_a, dm_wd, dm_Funct3); end
        step(); #1;
        n_cmp++; if (ld_stall !== 1'b0) begin n_bad++; $display("FAIL raw_release got %b want 0", ld_stall); end
        n_cmp++; if (dm_MemRead !== 1'b1 || dm_MemWrite !== 1'b0 || dm_a !== 9'h020 || dm_Funct3 !== 3'b010)
            begin n_bad++; $display("FAIL raw_load got rd=%b wr=%b a=%h f=%b want 1 0 020 010", dm_MemRead, dm_MemWrite, dm_a, dm_Funct3); end
        step();
        // Neighbouring word must not stall, and the load keeps the port.
        idle_inputs();
        st_valid = 1'b1; st_addr = 9'h024; st_data = 32'h12345678; st_funct3 = 3'b010;
        step();
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 9'h023; ld_funct3 = 3'b100; #1;
        n_cmp++; if (ld_stall !== 1'b0 || dm_MemRead !== 1'b1 || count !== 3'd1)
            begin n_bad++; $display("FAIL raw_neighbour got stall=%b rd=%b count=%0d want 0 1 1", ld_stall, dm_MemRead, count); end
        step();
        idle_inputs(); #1;
        n_cmp++; if (dm_MemWrite !== 1'b1 || dm_a !== 9'h024)
            begin n_bad++; $display("FAIL raw_late_drain got wr=%b a=%h want 1 024", dm_MemWrite, dm_a); end
        step();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_q[$];
        int pushed = 0;
        idle_inputs();
        for (int c = 0; c < 60; c++) begin
            int op;
            idle_inputs();
            op = (pushed < 7) ? $urandom_range(0, 2) : 1;
            if (op == 0) begin
                st_valid = 1'b1; st_addr = 9'($urandom_range(0, 63) * 4); st_data = $urandom; st_funct3 = 3'b010;
            end else if (op == 2) begin
                ld_valid = 1'b1; ld_addr = 9'h1F0; ld_funct3 = 3'b010;
            end
            #1;
            model_eval();
            if (st_valid && e_st_ready) begin
                exp_q.push_back(st_data);
                pushed++;
            end
            n_cmp++; if (count > 3'd4) begin n_bad++; $display("FAIL wrap_count got %0d want <=4", count); end
            if (dm_MemWrite === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL wrap_spurious got data=%h want no write", dm_wd); end
                else if (dm_wd !== exp_q[0]) begin n_bad++; $display("FAIL wrap_order got %h want %h", dm_wd, exp_q[0]); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            step();
        end
        n_cmp++; if (exp_q.size() != 0 || pushed != 7)
            begin n_bad++; $display("FAIL wrap_complete got left=%0d pushed=%0d want 0 7", exp_q.size(), pushed); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 250; c++) begin
            int op;
            idle_inputs();
            op = $urandom_range(0, 3);
            if (op == 1 || op == 3) begin
                st_valid = 1'b1; st_addr = 9'($urandom_range(0, 63)); st_data = $urandom; st_funct3 = 3'($urandom_range(0, 2));
            end else if (op == 2) begin
                ld_valid = 1'b1; ld_addr = 9'($urandom_range(0, 63)); ld_funct3 = 3'($urandom_range(0, 5));
            end
            #1;
            model_eval();
            n_cmp++; if (st_ready !== e_st_ready) begin n_bad++; $display("FAIL rnd_st_ready c=%0d got %b want %b", c, st_ready, e_st_ready); end
            n_cmp++; if (ld_stall !== e_ld_stall) begin n_bad++; $display("FAIL rnd_ld_stall c=%0d got %b want %b", c, ld_stall, e_ld_stall); end
            n_cmp++; if (dm_MemRead !== e_rd) begin n_bad++; $display("FAIL rnd_memread c=%0d got %b want %b", c, dm_MemRead, e_rd); end
            n_cmp++; if (dm_MemWrite !== e_wr) begin n_bad++; $display("FAIL rnd_memwrite c=%0d got %b want %b", c, dm_MemWrite, e_wr); end
            n_cmp++; if (dm_a !== e_a) begin n_bad++; $display("FAIL rnd_dm_a c=%0d got %h want %h", c, dm_a, e_a); end
            n_cmp++; if (dm_wd !== e_wd) begin n_bad++; $display("FAIL rnd_dm_wd c=%0d got %h want %h", c, dm_wd, e_wd); end
            n_cmp++; if (dm_Funct3 !== e_f3) begin n_bad++; $display("FAIL rnd_funct3 c=%0d got %b want %b", c, dm_Funct3, e_f3); end
            n_cmp++; if (count !== e_count) begin n_bad++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, e_count); end
            n_cmp++; if (empty !== e_empty) begin n_bad++; $display("FAIL rnd_empty c=%0d got %b want %b", c, empty, e_empty); end
            step();
        end
        idle_inputs();
        for (int c = 0; c < DEPTH + 1; c++) step();
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        ld_valid = 1'b1; ld_addr = 9'h100; ld_funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 9'(9'h080 + 4 * i); st_data = $urandom; st_funct3 = 3'b010;
            step();
        end
        idle_inputs(); #1;
        n_cmp++; if (dm_MemWrite !== 1'b1 || count !== 3'd3)
            begin n_bad++; $display("FAIL mid_pre got wr=%b count=%0d want 1 3", dm_MemWrite, count); end
        #1;
        reset_n = 1'b0;
        mq.delete();
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || st_ready !== 1'b1)
            begin n_bad++; $display("FAIL mid_rst_state got count=%0d empty=%b rdy=%b want 0 1 1", count, empty, st_ready); end
        n_cmp++; if (dm_MemWrite !== 1'b0 || dm_MemRead !== 1'b0 || dm_a !== 9'h0 || dm_wd !== 32'h0 || ld_stall !== 1'b0)
            begin n_bad++; $display("FAIL mid_rst_port got wr=%b rd=%b a=%h d=%h stall=%b want all 0", dm_MemWrite, dm_MemRead, dm_a, dm_wd, ld_stall); end
        step(); step();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (dm_MemWrite !== 1'b0 || count !== 3'd0)
                begin n_bad++; $display("FAIL mid_after[%0d] got wr=%b count=%0d want 0 0", c, dm_MemWrite, count); end
            step();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_drain();
        test_fill_under_load();
        test_raw_stall();
        test_wrap();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
